// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI4 master: turns a command plus data streams into INCR bursts.
// Completion is reported through a registered done pulse and a sticky-until-next err flag.
module axi_cmd_master #(
   parameter int unsigned            ID_BITS   = 4,
   parameter logic [ID_BITS-1:0]     ID        = '0,
   parameter int unsigned            ADDR_BITS = 32,
   parameter int unsigned            DATA_BITS = 32,
   parameter int unsigned            LEN_BITS  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_BITS-1:0]      cmd_addr,
   input  logic [LEN_BITS-1:0]       cmd_len,
   input  logic [DATA_BITS/8-1:0]    cmd_strb,
   input  logic [DATA_BITS-1:0]      wr_data,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   output logic [DATA_BITS-1:0]      rd_data,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic                      done,
   output logic                      err,
   output logic [ID_BITS-1:0]        ARID,
   output logic [ADDR_BITS-1:0]      ARADDR,
   output logic [LEN_BITS-1:0]       ARLEN,
   output logic [2:0]                ARSIZE,
   output logic [1:0]                ARBURST,
   output logic                      ARVALID,
   input  logic                      ARREADY,
   input  logic [ID_BITS-1:0]        RID,
   input  logic [DATA_BITS-1:0]      RDATA,
   input  logic [1:0]                RRESP,
   input  logic                      RLAST,
   input  logic                      RVALID,
   output logic                      RREADY,
   output logic [ID_BITS-1:0]        AWID,
   output logic [ADDR_BITS-1:0]      AWADDR,
   output logic [LEN_BITS-1:0]       AWLEN,
   output logic [2:0]                AWSIZE,
   output logic [1:0]                AWBURST,
   output logic                      AWVALID,
   input  logic                      AWREADY,
   output logic [DATA_BITS-1:0]      WDATA,
   output logic [DATA_BITS/8-1:0]    WSTRB,
   output logic                      WLAST,
   output logic                      WVALID,
   input  logic                      WREADY,
   input  logic [ID_BITS-1:0]        BID,
   input  logic [1:0]                BRESP,
   input  logic                      BVALID,
   output logic                      BREADY
);

   typedef enum logic [2:0] {
      S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR_BITS-1:0]     addr_q, addr_d;
   logic [LEN_BITS-1:0]      len_q, len_d;
   logic [LEN_BITS-1:0]      cnt_q, cnt_d;
   logic [DATA_BITS/8-1:0]   strb_q, strb_d;
   logic                     acc_q, acc_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic                     beat_err;

   // Direction is carried by the state itself, so no separate write flag is kept.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      strb_d   = strb_q;
      acc_d    = acc_q;
      done_d   = 1'b0;
      err_d    = err_q;
      beat_err = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               strb_d  = cmd_strb;
               cnt_d   = '0;
               acc_d   = 1'b0;
               state_d = cmd_write ? S_WADDR : S_RADDR;
            end
         end
         S_RADDR: if (ARREADY) state_d = S_RDATA;
         S_WADDR: if (AWREADY) state_d = S_WDATA;
         S_WDATA: begin
            if (wr_valid && WREADY) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == len_q) state_d = S_WRESP;
            end
         end
         S_WRESP: begin
            if (BVALID) begin
               done_d  = 1'b1;
               err_d   = acc_q | (BRESP != 2'b00) | (BID != ID);
               state_d = S_IDLE;
            end
         end
         S_RDATA: begin
            if (RVALID && rd_ready) begin
               // A short burst shows at RLAST; a long one at the first beat past len.
               beat_err = (RRESP != 2'b00) | (RID != ID) |
                          (RLAST ? (cnt_q != len_q) : (cnt_q == len_q));
               cnt_d    = cnt_q + 1'b1;
               acc_d    = acc_q | beat_err;
               if (RLAST) begin
                  done_d  = 1'b1;
                  err_d   = acc_q | beat_err;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         strb_q  <= '0;
         acc_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         strb_q  <= strb_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign done      = done_q;
   assign err       = err_q;

   assign ARID      = ID;
   assign ARADDR    = addr_q;
   assign ARLEN     = len_q;
   assign ARSIZE    = 3'b010;
   assign ARBURST   = 2'b01;
   assign ARVALID   = (state_q == S_RADDR);

   assign AWID      = ID;
   assign AWADDR    = addr_q;
   assign AWLEN     = len_q;
   assign AWSIZE    = 3'b010;
   assign AWBURST   = 2'b01;
   assign AWVALID   = (state_q == S_WADDR);

   assign WDATA     = wr_data;
   assign WSTRB     = strb_q;
   assign WLAST     = (cnt_q == len_q);
   assign WVALID    = (state_q == S_WDATA) & wr_valid;
   assign wr_ready  = (state_q == S_WDATA) & WREADY;

   assign rd_data   = RDATA;
   assign rd_valid  = (state_q == S_RDATA) & RVALID;
   assign RREADY    = (state_q == S_RDATA) & rd_ready;

   assign BREADY    = (state_q == S_WRESP);

endmodule

// File: tb/tb_axi_cmd_master.sv
// Bench for axi_cmd_master: directed and randomized commands against a transaction-level
// slave model; expected beats and error status come from per-command arithmetic.
module tb_axi_cmd_master;

   localparam logic [3:0] TID = 4'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic [3:0]  cmd_strb;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_ready;
   logic        done, err;
   logic [3:0]  ARID;   logic [31:0] ARADDR; logic [3:0] ARLEN; logic [2:0] ARSIZE;
   logic [1:0]  ARBURST; logic ARVALID, ARREADY;
   logic [3:0]  RID;    logic [31:0] RDATA;  logic [1:0] RRESP; logic RLAST, RVALID, RREADY;
   logic [3:0]  AWID;   logic [31:0] AWADDR; logic [3:0] AWLEN; logic [2:0] AWSIZE;
   logic [1:0]  AWBURST; logic AWVALID, AWREADY;
   logic [31:0] WDATA;  logic [3:0] WSTRB;   logic WLAST, WVALID, WREADY;
   logic [3:0]  BID;    logic [1:0] BRESP;   logic BVALID, BREADY;

   int checks = 0;
   int errors = 0;

   axi_cmd_master #(.ID_BITS(4), .ID(TID), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_strb(cmd_strb),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .err(err),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_strb = '0;
      wr_data = '0; wr_valid = 0; rd_ready = 0;
      ARREADY = 0; AWREADY = 0; WREADY = 0;
      RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
      BID = '0; BRESP = '0; BVALID = 0;
   endtask

   // Drives one command and waits for its acceptance edge; returns just after the next negedge.
   task automatic issue(input bit wr, input logic [31:0] addr, input int unsigned len,
                        input logic [3:0] strb);
      logic [31:0] r;
      @(negedge clk);
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len[3:0]; cmd_strb = strb;
      #1 check("cmd_ready_idle", cmd_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      r = $urandom;
      cmd_valid = 0; cmd_addr = r; cmd_len = r[3:0]; cmd_strb = r[7:4]; cmd_write = r[8];
   endtask

   task automatic do_write(input logic [31:0] addr, input int unsigned len, input logic [3:0] strb,
                           input logic [31:0] d0, input logic [1:0] bresp, input logic [3:0] bid,
                           input int unsigned aw_stall, input bit fast);
      logic [31:0] data[$];
      bit          exp_err, hs, fin;
      int unsigned beat, edges, dly;
      for (int unsigned i = 0; i <= len; i++) data.push_back(i == 0 ? d0 : $urandom);
      exp_err = (bresp != 2'b00) || (bid != TID);
      issue(1'b1, addr, len, strb);
      edges = 0; fin = 0;
      for (int n = 0; n < 200 && !fin; n++) begin
         AWREADY  = (n < int'(aw_stall)) ? 1'b0 : (fast ? 1'b1 : 1'($urandom));
         wr_valid = 1'($urandom); WREADY = 1'($urandom);
         #1;
         check("awvalid", AWVALID, 1'b1);
         check("awaddr", AWADDR, addr);
         check("awlen", AWLEN, len);
         check("awsize_burst_id", {AWSIZE, AWBURST, AWID}, {3'b010, 2'b01, TID});
         check("wvalid_before_aw", {WVALID, wr_ready}, 2'b00);
         hs = AWREADY;
         @(posedge clk); edges++; @(negedge clk);
         if (hs) fin = 1;
      end
      if (!fin) check("aw_timeout", 0, 1);
      AWREADY = 0;
      beat = 0; fin = 0;
      for (int n = 0; n < 400 && !fin; n++) begin
         wr_valid = fast ? 1'b1 : (($urandom % 3) != 0);
         WREADY   = fast ? 1'b1 : 1'($urandom);
         wr_data  = data[beat];
         #1;
         check("wvalid_pass", WVALID, wr_valid);
         check("wr_ready_pass", wr_ready, WREADY);
         check("wdata", WDATA, data[beat]);
         check("wstrb", WSTRB, strb);
         check("wlast", WLAST, beat == len);
         check("bready_in_w", {BREADY, AWVALID}, 2'b00);
         hs = wr_valid && WREADY;
         @(posedge clk); edges++; @(negedge clk);
         if (hs) begin
            beat++;
            if (beat == len + 1) fin = 1;
         end
      end
      if (!fin) check("w_timeout", 0, 1);
      dly = fast ? 0 : $urandom % 3;
      fin = 0;
      for (int n = 0; n < 50 && !fin; n++) begin
         wr_valid = 1; WREADY = 1;
         BVALID = (n >= int'(dly)); BRESP = bresp; BID = bid;
         #1;
         check("bready", BREADY, 1'b1);
         check("no_extra_w", {WVALID, wr_ready}, 2'b00);
         check("done_early", done, 1'b0);
         hs = BVALID;
         @(posedge clk); edges++; @(negedge clk);
         if (hs) fin = 1;
      end
      if (!fin) check("b_timeout", 0, 1);
      BVALID = 0; wr_valid = 0; WREADY = 0;
      #1;
      check("wr_done", done, 1'b1);
      check("wr_err", err, exp_err);
      check("wr_cmd_ready", {cmd_ready, BREADY}, 2'b10);
      if (fast) check("wr_latency", edges, 3);
      @(negedge clk); #1;
      check("wr_done_pulse", done, 1'b0);
      check("wr_err_hold", err, exp_err);
   endtask

   task automatic do_read(input logic [31:0] addr, input int unsigned len, input int unsigned nbeats,
                          input bit seq_data, input logic [31:0] base,
                          input int bad_rid, input logic [3:0] rid_v,
                          input int bad_resp, input logic [1:0] resp_v,
                          input bit toggle, input int rst_beat);
      logic [31:0] data[$];
      bit          exp_err, hs, fin, tg;
      int unsigned beat;
      for (int unsigned i = 0; i < nbeats; i++) data.push_back(seq_data ? base + i : $urandom);
      exp_err = (nbeats != len + 1) ||
                (bad_rid >= 0 && bad_rid < int'(nbeats) && rid_v != TID) ||
                (bad_resp >= 0 && bad_resp < int'(nbeats) && resp_v != 2'b00);
      issue(1'b0, addr, len, 4'h0);
      fin = 0;
      for (int n = 0; n < 200 && !fin; n++) begin
         ARREADY = 1'($urandom); rd_ready = 1'($urandom); RVALID = 1'($urandom);
         #1;
         check("arvalid", ARVALID, 1'b1);
         check("araddr", ARADDR, addr);
         check("arlen", ARLEN, len);
         check("arsize_burst_id", {ARSIZE, ARBURST, ARID}, {3'b010, 2'b01, TID});
         check("r_before_ar", {RREADY, rd_valid, AWVALID}, 3'b000);
         hs = ARREADY;
         @(posedge clk); @(negedge clk);
         if (hs) fin = 1;
      end
      if (!fin) check("ar_timeout", 0, 1);
      ARREADY = 0;
      beat = 0; fin = 0; tg = 1;
      for (int n = 0; n < 400 && !fin; n++) begin
         if (rst_beat >= 0 && int'(beat) == rst_beat) begin
            RVALID = 1; rd_ready = 1; wr_valid = 1; WREADY = 1; RDATA = data[beat]; RLAST = 0;
            #1 rst = 0;
            #1;
            check("rst_ar_aw", {ARVALID, AWVALID}, 2'b00);
            check("rst_w", {WVALID, wr_ready}, 2'b00);
            check("rst_r", {RREADY, rd_valid}, 2'b00);
            check("rst_b_cmd", {BREADY, cmd_ready}, 2'b01);
            idle_inputs();
            @(posedge clk); @(negedge clk); #1;
            check("rst_no_done", {done, err}, 2'b00);
            rst = 1;
            @(negedge clk); #1;
            check("rst_release", {cmd_ready, done}, 2'b10);
            return;
         end
         RVALID   = (($urandom % 4) != 0);
         rd_ready = toggle ? tg : 1'($urandom);
         tg       = ~tg;
         RDATA    = data[beat];
         RID      = (int'(beat) == bad_rid) ? rid_v : TID;
         RRESP    = (int'(beat) == bad_resp) ? resp_v : 2'b00;
         RLAST    = (beat == nbeats - 1);
         #1;
         check("rready_pass", RREADY, rd_ready);
         check("rd_valid_pass", rd_valid, RVALID);
         if (RVALID) check("rd_data", rd_data, data[beat]);
         check("r_done_early", done, 1'b0);
         hs = RVALID && rd_ready;
         @(posedge clk); @(negedge clk);
         if (hs) begin
            if (RLAST) fin = 1;
            beat++;
         end
      end
      if (!fin) check("r_timeout", 0, 1);
      RVALID = 0; RLAST = 0; rd_ready = 0;
      #1;
      check("rd_done", done, 1'b1);
      check("rd_err", err, exp_err);
      check("rd_cmd_ready", {cmd_ready, RREADY}, 2'b10);
      @(negedge clk); #1;
      check("rd_done_pulse", done, 1'b0);
      check("rd_err_hold", err, exp_err);
   endtask

   initial begin
      idle_inputs();
      rst = 0;
      wr_valid = 1; WREADY = 1; RVALID = 1; rd_ready = 1; BVALID = 1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_cmd_ready", cmd_ready, 1'b1);
      check("reset_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 5'b0);
      check("reset_stream", {wr_ready, rd_valid}, 2'b00);
      check("reset_done_err", {done, err}, 2'b00);
      idle_inputs();
      #1 rst = 1;

      do_write(32'h1000_0300, 0, 4'hF, 32'h0000_00FF, 2'b00, TID, 0, 1'b1);
      do_read(32'h1000_0100, 3, 4, 1'b1, 32'hA0, -1, TID, -1, 2'b00, 1'b1, -1);
      do_write(32'h2000_0000, 15, 4'h5, $urandom, 2'b00, TID, 5, 1'b0);
      do_write(32'h3000_0040, 2, 4'hC, $urandom, 2'b10, TID, 1, 1'b0);
      do_read(32'h3000_0080, 2, 3, 1'b0, 32'h0, 1, 4'd3, -1, 2'b00, 1'b0, -1);
      do_read(32'h3000_00C0, 1, 2, 1'b0, 32'h0, -1, TID, -1, 2'b00, 1'b0, -1);
      do_read(32'h4000_0000, 3, 3, 1'b1, 32'hB0, -1, TID, -1, 2'b00, 1'b0, -1);
      do_read(32'h4000_0100, 1, 4, 1'b1, 32'hC0, -1, TID, -1, 2'b00, 1'b0, -1);
      do_read(32'h4000_0200, 15, 16, 1'b0, 32'h0, -1, TID, 7, 2'b11, 1'b0, -1);
      do_read(32'h5000_0000, 3, 4, 1'b1, 32'hD0, -1, TID, -1, 2'b00, 1'b0, 1);
      do_write(32'h5000_0100, 1, 4'hF, 32'h1234_5678, 2'b00, TID, 0, 1'b0);
      do_write(32'h6000_0000, 0, 4'h3, 32'h1, 2'b00, 4'd9, 0, 1'b1);
      do_write(32'h6000_0004, 0, 4'hF, 32'h2, 2'b00, TID, 0, 1'b1);

      for (int k = 0; k < 14; k++) begin
         int unsigned len;
         len = $urandom_range(15, 0);
         if ($urandom % 2) begin
            do_write($urandom, len, 4'($urandom), $urandom,
                     (($urandom % 4) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
                     (($urandom % 5) == 0) ? 4'($urandom_range(15, 1)) : TID,
                     $urandom % 3, 1'b0);
         end else begin
            do_read($urandom, len,
                    (($urandom % 4) == 0) ? $urandom_range(len + 3, 1) : len + 1,
                    1'b0, 32'h0,
                    (($urandom % 4) == 0) ? int'($urandom_range(len, 0)) : -1,
                    4'($urandom_range(15, 1)),
                    (($urandom % 4) == 0) ? int'($urandom_range(len, 0)) : -1,
                    2'($urandom_range(3, 1)), 1'($urandom), -1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
